vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; next generation of the fixed 640x480 VController.
- Adds programmable horizontal/vertical timing, sync polarity, counter width, pixel-clock divider, run enable, active-video flag and line/frame strobes.
- Sits between the system clock domain and the pixel pipeline.
- hcount/vcount address the frame buffer; hsync/vsync drive the DAC/connector.

---
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and the pixel pipeline (slave).
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          en;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          pix_tick;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en,
        output hcount, vcount, hsync, vsync, video_on, pix_tick, line_start, frame_start
    );

    modport slave (
        output en,
        input  hcount, vcount, hsync, vsync, video_on, pix_tick, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with programmable porches, sync polarity,
// pixel-clock divider, run enable and line/frame strobes.
module vga_timing_gen #(
    parameter int CW       = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    vga_timing_gen_if.master tmg_io
);
    // state | meaning
    // IDLE  | out of reset, outputs at reset values, waiting for en
    // RUN   | raster running; en low pauses with divider, counters and levels held
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Inclusive bounds keep every constant inside CW bits even when a total equals 2^CW.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [CW-1:0] hcount_q;
    logic [CW-1:0] vcount_q;
    logic          hsync_q;
    logic          vsync_q;
    logic          video_on_q;
    logic          pix_tick_q;
    logic          line_start_q;
    logic          frame_start_q;

    logic [DW-1:0] div_d;
    logic [CW-1:0] hcount_d;
    logic [CW-1:0] vcount_d;
    logic          tick_d;
    logic          h_wrap;
    logic          v_wrap;

    function automatic logic hsync_lvl(input logic [CW-1:0] h);
        return (h >= HS_FIRST && h <= HS_LAST) ? HS_POL : ~HS_POL;
    endfunction

    function automatic logic vsync_lvl(input logic [CW-1:0] v);
        return (v >= VS_FIRST && v <= VS_LAST) ? VS_POL : ~VS_POL;
    endfunction

    function automatic logic active(input logic [CW-1:0] h, input logic [CW-1:0] v);
        return (h <= H_ACT_LAST) && (v <= V_ACT_LAST);
    endfunction

    always_comb begin
        tick_d   = (div_q == DIV_LAST);
        div_d    = tick_d ? '0 : div_q + DW'(1);
        h_wrap   = (hcount_q == H_LAST);
        v_wrap   = (vcount_q == V_LAST);
        hcount_d = h_wrap ? '0 : hcount_q + CW'(1);
        vcount_d = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount_q + CW'(1);
        end
    end

    // Levels are decoded from the next counter values so they land in the same cycle as hcount/vcount.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            video_on_q    <= 1'b0;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tmg_io.en) begin
                        state_q       <= S_RUN;
                        div_q         <= '0;
                        hcount_q      <= '0;
                        vcount_q      <= '0;
                        hsync_q       <= hsync_lvl('0);
                        vsync_q       <= vsync_lvl('0);
                        video_on_q    <= active('0, '0);
                        pix_tick_q    <= 1'b1;
                        line_start_q  <= 1'b1;
                        frame_start_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (tmg_io.en) begin
                        div_q <= div_d;
                        if (tick_d) begin
                            hcount_q      <= hcount_d;
                            vcount_q      <= vcount_d;
                            hsync_q       <= hsync_lvl(hcount_d);
                            vsync_q       <= vsync_lvl(vcount_d);
                            video_on_q    <= active(hcount_d, vcount_d);
                            pix_tick_q    <= 1'b1;
                            line_start_q  <= h_wrap;
                            frame_start_q <= h_wrap && v_wrap;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tmg_io.hcount      = hcount_q;
    assign tmg_io.vcount      = vcount_q;
    assign tmg_io.hsync       = hsync_q;
    assign tmg_io.vsync       = vsync_q;
    assign tmg_io.video_on    = video_on_q;
    assign tmg_io.pix_tick    = pix_tick_q;
    assign tmg_io.line_start  = line_start_q;
    assign tmg_io.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets compared cycle by cycle against a
// pixel-index model through an expected-value queue, plus period and async-reset checks.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       ls;
        logic       fs;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n, rst_c_n;

    vga_timing_gen_if #(.CW(10)) if_a ();
    vga_timing_gen_if #(.CW(10)) if_b ();
    vga_timing_gen_if #(.CW(10)) if_c ();

    // a: defaults; b: short lines with default vertical timing; c: tiny raster, divided clock, active-high syncs
    vga_timing_gen u_a (.clk_i(clk), .rst_n_i(rst_a_n), .tmg_io(if_a));

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2)
    ) u_b (.clk_i(clk), .rst_n_i(rst_b_n), .tmg_io(if_b));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(2)
    ) u_c (.clk_i(clk), .rst_n_i(rst_c_n), .tmg_io(if_c));

    // Independent timing tables, written out per instance (sync windows are [first, end)).
    int ht  [3] = '{800, 24, 8};
    int vt  [3] = '{525, 525, 6};
    int ha  [3] = '{640, 16, 4};
    int va  [3] = '{480, 480, 3};
    int hs0 [3] = '{656, 18, 5};
    int hs1 [3] = '{752, 22, 7};
    int vs0 [3] = '{490, 490, 4};
    int vs1 [3] = '{492, 492, 5};
    int dv  [3] = '{1, 1, 2};
    bit hp  [3] = '{1'b0, 1'b0, 1'b1};
    bit vp  [3] = '{1'b0, 1'b0, 1'b1};

    out_t   exp_q[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    bit     m_rst;
    bit     m_run;
    longint m_k;
    out_t   m_last;
    int     last_fs, last_ls, last_pt, fs_per, ls_per, pt_per;

    function automatic out_t reset_vals(input int sel);
        out_t o;
        o    = '0;
        o.hs = ~hp[sel];
        o.vs = ~vp[sel];
        return o;
    endfunction

    // Output after run clock k (k = 0 is the start edge) as a function of the pixel index.
    function automatic out_t decode(input int sel, input longint k);
        out_t   o;
        longint p;
        int     h, v;
        p     = k / dv[sel];
        h     = int'(p % ht[sel]);
        v     = int'((p / ht[sel]) % vt[sel]);
        o.h   = 10'(h);
        o.v   = 10'(v);
        o.hs  = (h >= hs0[sel] && h < hs1[sel]) ? hp[sel] : ~hp[sel];
        o.vs  = (v >= vs0[sel] && v < vs1[sel]) ? vp[sel] : ~vp[sel];
        o.von = (h < ha[sel]) && (v < va[sel]);
        o.pt  = (k % dv[sel]) == 0;
        o.ls  = o.pt && (h == 0);
        o.fs  = o.ls && (v == 0);
        return o;
    endfunction

    function automatic out_t sample(input int sel);
        out_t o;
        case (sel)
            0:       o = {if_a.hcount, if_a.vcount, if_a.hsync, if_a.vsync, if_a.video_on, if_a.pix_tick, if_a.line_start, if_a.frame_start};
            1:       o = {if_b.hcount, if_b.vcount, if_b.hsync, if_b.vsync, if_b.video_on, if_b.pix_tick, if_b.line_start, if_b.frame_start};
            default: o = {if_c.hcount, if_c.vcount, if_c.hsync, if_c.vsync, if_c.video_on, if_c.pix_tick, if_c.line_start, if_c.frame_start};
        endcase
        return o;
    endfunction

    task automatic check(input int sel, input string tag, output out_t o);
        out_t e;
        o = sample(sel);
        e = exp_q.pop_front();
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed h=%0d v=%0d hs,vs,von,pt,ls,fs=%b%b%b%b%b%b expected h=%0d v=%0d hs,vs,von,pt,ls,fs=%b%b%b%b%b%b",
                   tag, cyc, o.h, o.v, o.hs, o.vs, o.von, o.pt, o.ls, o.fs,
                   e.h, e.v, e.hs, e.vs, e.von, e.pt, e.ls, e.fs);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic new_run();
        last_fs = -1; last_ls = -1; last_pt = -1;
        fs_per  = -1; ls_per  = -1; pt_per  = -1;
    endtask

    // Drive one clock: predict the post-edge outputs, queue them, then compare on the falling edge.
    task automatic step(input int sel, input bit en_v, input string tag);
        out_t e, o;
        case (sel)
            0:       if_a.en = en_v;
            1:       if_b.en = en_v;
            default: if_c.en = en_v;
        endcase
        if (m_rst) begin
            e = reset_vals(sel);
        end else if (!m_run) begin
            if (en_v) begin
                m_run = 1'b1;
                m_k   = 0;
                e     = decode(sel, 0);
            end else begin
                e = reset_vals(sel);
            end
        end else if (en_v) begin
            m_k++;
            e = decode(sel, m_k);
        end else begin
            e    = m_last;
            e.pt = 1'b0;
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
        m_last = e;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check(sel, tag, o);
        if (o.fs) begin
            if (last_fs >= 0) fs_per = cyc - last_fs;
            last_fs = cyc;
        end
        if (o.ls) begin
            if (last_ls >= 0) ls_per = cyc - last_ls;
            last_ls = cyc;
        end
        if (o.pt) begin
            if (last_pt >= 0) pt_per = cyc - last_pt;
            last_pt = cyc;
        end
    endtask

    initial begin
        out_t o;
        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        if_a.en = 1'b0; if_b.en = 1'b0; if_c.en = 1'b0;
        m_rst = 1'b1; m_run = 1'b0; m_k = 0;
        new_run();

        // Defaults: reset, idle, line timing, then a 7-clock pause at (100, 3)
        repeat (3) step(0, 1'b0, "a_reset");
        rst_a_n = 1'b1; m_rst = 1'b0;
        repeat (2) step(0, 1'b0, "a_idle");
        repeat (2501) step(0, 1'b1, "a_run");
        check_val("a_line_period", ls_per, 800);
        o = sample(0);
        check_val("a_pause_at_h", int'(o.h), 100);
        check_val("a_pause_at_v", int'(o.v), 3);
        repeat (7) step(0, 1'b0, "a_pause");
        step(0, 1'b1, "a_resume");
        o = sample(0);
        check_val("a_resume_h", int'(o.h), 101);
        repeat (900) step(0, 1'b1, "a_run2");
        rst_a_n = 1'b0; m_rst = 1'b1; m_run = 1'b0;

        // Short lines, default vertical: async reset inside vsync, then full frames
        rst_b_n = 1'b1; m_rst = 1'b0; new_run();
        repeat (11805) step(1, 1'b1, "b_run");
        o = sample(1);
        check_val("b_pre_reset_v", int'(o.v), 491);
        check_val("b_pre_reset_vsync", int'(o.vs), 0);
        #2;
        rst_b_n = 1'b0;
        #1;
        m_rst = 1'b1; m_run = 1'b0;
        exp_q.push_back(reset_vals(1));
        check(1, "b_async_reset", o);
        step(1, 1'b1, "b_in_reset");
        rst_b_n = 1'b1; m_rst = 1'b0; new_run();
        repeat (25202) step(1, 1'b1, "b_run2");
        check_val("b_frame_period", fs_per, 12600);
        check_val("b_line_period", ls_per, 24);
        rst_b_n = 1'b0; m_rst = 1'b1; m_run = 1'b0;

        // Tiny raster, CLK_DIV=2: periods, then a pause in mid divider phase
        rst_c_n = 1'b1; m_rst = 1'b0; new_run();
        repeat (193) step(2, 1'b1, "c_run");
        check_val("c_frame_period", fs_per, 96);
        check_val("c_tick_period", pt_per, 2);
        check_val("c_line_period", ls_per, 16);
        repeat (13) step(2, 1'b1, "c_run");
        repeat (7) step(2, 1'b0, "c_pause");
        repeat (90) step(2, 1'b1, "c_resume");
        check_val("c_paused_frame_period", fs_per, 103);
        rst_c_n = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
